counter_mod: RTL
================

COUNTER_MOD -- requirements
Module: counter_mod

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 4, meaning counter width in bits, legal range 1..32.
REQ-002 The block SHALL provide parameter MODULUS, default 16, meaning count cycle length, legal range 2..2^WIDTH.
REQ-003 The block SHALL provide port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 The block SHALL provide port rst, input, 1, reset, synchronous, active-high.
REQ-005 The block SHALL provide port clr_n, input, 1, synchronous clear, active-low.
REQ-006 The block SHALL provide port load_n, input, 1, synchronous parallel load, active-low.
REQ-007 The block SHALL provide ports enp and ent, input, 1 each, count enables; counting requires both high.
REQ-008 The block SHALL provide port up, input, 1: 1 = count up, 0 = count down.
REQ-009 The block SHALL provide port d, input, WIDTH, parallel load data.
REQ-010 The block SHALL provide port q, output, WIDTH, current count, registered.
REQ-011 The block SHALL provide port rco, output, 1, combinational ripple carry/borrow for cascading.
REQ-012 The block SHALL provide port wrap, output, 1, registered one-cycle wrap-event pulse.

Function
REQ-013 Per-edge priority SHALL be: rst > clr_n low > load_n low > count (enp&ent) > hold.
REQ-014 clr_n low (rst low) SHALL set q to 0 at the next edge, independent of enables and up.
REQ-015 load_n low (rst low, clr_n high) SHALL set q to d at the next edge, independent of enables; d values >= MODULUS are loaded unchanged.
REQ-016 Count up: q = MODULUS-1 SHALL wrap to 0; any q >= MODULUS-1 SHALL also go to 0; otherwise q+1.
REQ-017 Count down: q = 0 SHALL wrap to MODULUS-1; otherwise q-1, including q >= MODULUS.
REQ-018 Arithmetic SHALL be unsigned WIDTH-bit; no intermediate value may exceed WIDTH bits on q.
REQ-019 With enp&ent low and no clear/load, q SHALL hold.
REQ-020 rco SHALL equal ent & (up ? q == MODULUS-1 : q == 0), combinational from current q, ent, up; independent of enp, clr_n, load_n.
REQ-021 wrap SHALL be 1 for exactly the cycle after an edge on which a count-enabled wrap (REQ-016/017 wrap branch) occurred, else 0; clear and load never set wrap.
REQ-022 up changing while counting SHALL take effect at the next edge with no extra latency.
REQ-023 Counting latency SHALL be one edge: q updates on the edge where enables are sampled high.
REQ-024 Cascading SHALL work by driving the next stage's ent from this stage's rco, with enp and clk shared.

Reset
REQ-025 rst high at an edge SHALL set q = 0 and wrap = 0, overriding all other inputs; mid-count reset discards the count.
REQ-026 After reset, rco SHALL read ent & ~up & 1 (q = 0), i.e. follows ent when up = 0, 0 when up = 1.
REQ-027 No initial-value dependence: behaviour before first rst is undefined and not checked.

Verification
REQ-028 WIDTH=4, MODULUS=10, up=1, enp=ent=1 from reset, 12 edges -> q 1..9,0,1,2; rco high while q=9; wrap high one cycle after q 9->0.
REQ-029 WIDTH=4, MODULUS=10, up=0 from q=0 -> next q=9, wrap pulses, rco high while q=0 and ent=1.
REQ-030 load_n=0, d=13, MODULUS=10, then count up -> q=13 then 0 with wrap=1; count down from 13 -> 12.
REQ-031 Simultaneous clr_n=0, load_n=0, enp=ent=1, d=5 at q=7 -> q=0, wrap=0; rst=1 same cycle also -> q=0.
REQ-032 Two instances cascaded (WIDTH=4, MODULUS=10) -> 00..99 decimal sequence, high digit advances only when low digit rco=1; 99 -> 00.
REQ-033 enp=0, ent=1 at q=MODULUS-1 -> q holds, rco=1, wrap=0; ent=0 -> rco=0.

Source files
------------

// File: rtl/counter_mod_if.sv
// counter_mod_if: counter control/data bundle (clr_n, load_n, enp, ent, up, d in; q, rco, wrap out)
interface counter_mod_if #(
  parameter int WIDTH = 4
);
  logic             clr_n;
  logic             load_n;
  logic             enp;
  logic             ent;
  logic             up;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             rco;
  logic             wrap;
  modport slave (
    input  clr_n, load_n, enp, ent, up, d,
    output q, rco, wrap
  );
  modport master (
    output clr_n, load_n, enp, ent, up, d,
    input  q, rco, wrap
  );
endinterface

// File: rtl/counter_mod.sv
// counter_mod: modulo up/down counter (clk, rst; bus: clr_n/load_n/enp/ent/up/d in, q/wrap registered, rco combinational)
module counter_mod #(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic         clk,
  input  logic         rst,
  counter_mod_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             w_cnt;
  logic             w_up_wrap;
  logic             w_dn_wrap;
  logic             w_wrap_evt;
  logic [WIDTH-1:0] w_next;
  always_comb begin
    w_cnt      = bus.enp & bus.ent;
    w_up_wrap  = r_q >= MAX;
    w_dn_wrap  = r_q == '0;
    w_wrap_evt = w_cnt & (bus.up ? w_up_wrap : w_dn_wrap);
    w_next     = bus.up ? (w_up_wrap ? '0 : r_q + 1'b1) : (w_dn_wrap ? MAX : r_q - 1'b1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= !bus.clr_n ? '0 : !bus.load_n ? bus.d : w_cnt ? w_next : r_q;
      r_wrap <= bus.clr_n & bus.load_n & w_wrap_evt;
    end
  end
  assign bus.q    = r_q;
  assign bus.wrap = r_wrap;
  assign bus.rco  = bus.ent & (bus.up ? r_q == MAX : r_q == '0);
endmodule
